parallel_cpu_2_mult_seq: RTL and testbench
==========================================

// Module: parallel_cpu_2_mult_seq
// PURPOSE
//  Issue-side sequencer and result combiner for the 16x16 three-partial-product multiply cell.
//  Takes a 32x32 multiply request and drives operands plus enable into the cell.
//  Combines p1=a.lo*b.lo, p2=a.lo*b.hi and p3=a.hi*b.lo into the 32-bit product word.
//  For high-word ops, issues a second pass to obtain a.hi*b.hi and returns bits [63:32].
//  Sits between the CPU custom/mul issue path and the cell.
// PARAMETERS
//  DATA_W    32  operand/result width; only 32 supported; HALF_W=DATA_W/2 derived localparam
//  CELL_LAT  1   cycles from cell_en-high to valid cell_p*; legal 1..3
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   async active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   sequencer idle, may accept
//  req_op     in   2   00 MUL(lo), 01 MULXUU, 10 MULXSU (a signed, b unsigned), 11 MULXSS
//  req_a      in   32  operand a
//  req_b      in   32  operand b
//  kill       in   1   sync abort of in-flight op (pipeline flush)
//  cell_src1  out  32  to cell E_src1
//  cell_src2  out  32  to cell E_src2
//  cell_en    out  1   to cell M_en
//  cell_p1    in   32  a.lo*b.lo from cell
//  cell_p2    in   32  a.lo*b.hi from cell
//  cell_p3    in   32  a.hi*b.lo from cell
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   consumer takes result
//  rsp_data   out  32  result word
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; cell_en=0; cell_src1/2=0; latched a,b,op=0.
//  Accept: when req_valid&&req_ready in IDLE, latch a,b,op. Only IDLE asserts req_ready.
//  FSM: IDLE -> ISSUE_LO -> WAIT_LO -> (MUL: RESP | MULX: WAIT_HI) -> RESP -> IDLE.
//   ISSUE_LO (1 cyc): cell_src1=a, cell_src2=b, cell_en=1.
//   WAIT_LO: cell_en=0, src held; down-counter of CELL_LAT; at expiry capture p1/p2/p3.
//   MULX issue_hi: in the capture cycle, drive src1={16'h0,a[31:16]}, src2={16'h0,b[31:16]}, cell_en=1.
//   WAIT_HI: cell_p1 after CELL_LAT cycles is hh = a.hi*b.hi, captured.
//   RESP: rsp_valid=1; rsp_data stable until rsp_ready; RESP->IDLE on rsp_ready.
//  Latency (CELL_LAT=1, rsp_ready=1), accept at cycle T:
//   MUL  -> rsp_valid at T+3
//   MULX -> rsp_valid at T+4
//   Throughput: one op per latency+1 cycles.
//  Arithmetic (all unsigned, wrap mod 2^32 on result):
//   mid[32:0]  = p2+p3
//   lo[32:0]   = p1 + {mid[15:0],16'h0}; c = lo[32]
//   MUL        = lo[31:0]
//   hu         = hh + mid[32:16] + c
//   MULXUU     = hu
//   MULXSU     = hu - (a[31]?b:0)
//   MULXSS     = hu - (a[31]?b:0) - (b[31]?a:0)
//  kill: any state -> IDLE next cycle; rsp_valid=0, cell_en=0.
//   kill beats rsp_ready in the same cycle: result dropped, not handed over.
//   kill in IDLE with req_valid: no accept.
//  Async reset mid-op: immediate return to reset values; no partial result later.
//  cell_en is never high outside ISSUE_LO and the issue_hi cycle.
// STRUCTURE
//  Shared package parallel_cpu_2_mult_pkg:
//   op enum (MUL, MULXUU, MULXSU, MULXSS)
//   FSM state enum
//   HALF_W constant
//  One sub-module parallel_cpu_2_mult_combine: combinational reduction of p1/p2/p3/hh/op/a/b into the result word.
//  FSM, counter, latches and handshake stay in the top.
// TESTING
//  MUL a=0x0001_0003 b=0x0002_0005 -> rsp_data=0x000B_000F, rsp_valid at T+3.
//  MULXUU a=b=0xFFFF_FFFF -> rsp_data=0xFFFF_FFFE at T+4; exactly two cell_en pulses.
//  MULXSS a=0xFFFF_FFFF b=0x0000_0002 -> 0xFFFF_FFFF; MULXSU a=b=0xFFFF_FFFF -> 0xFFFF_FFFF.
//  rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_valid stable, req_ready=0; new req accepted the cycle after rsp_ready.
//  kill in WAIT_LO, and reset_n low in WAIT_HI -> no rsp_valid, IDLE next cycle; next MUL 3*5 -> 0x0000_000F.
//  CELL_LAT=2 build, random ops vs 64-bit model -> MUL at T+4, MULX at T+6, all results match.

Source files
------------

// File: rtl/parallel_cpu_2_mult_pkg.sv
// Shared types and constants for the 32x32 multiply sequencer and its result combiner.
package parallel_cpu_2_mult_pkg;

  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RESP
  } state_e;

endpackage

// File: rtl/parallel_cpu_2_mult_combine.sv
// Combinational reduction of the cell partial products into the 32-bit result word.
module parallel_cpu_2_mult_combine
  import parallel_cpu_2_mult_pkg::*;
(
  input  op_e         i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_p1,
  input  logic [31:0] i_p2,
  input  logic [31:0] i_p3,
  input  logic [31:0] i_hh,
  output logic [31:0] o_result
);

  logic [32:0] w_mid;
  logic [32:0] w_lo;
  logic [31:0] w_hu;

  always_comb begin
    w_mid = {1'b0, i_p2} + {1'b0, i_p3};
    w_lo  = {1'b0, i_p1} + {1'b0, w_mid[HALF_W-1:0], {HALF_W{1'b0}}};
    // Upper word: hh plus the cross-term overflow and the carry out of the low word.
    w_hu  = i_hh + {15'h0, w_mid[32:HALF_W]} + {31'h0, w_lo[32]};
    case (i_op)
      OP_MUL:    o_result = w_lo[31:0];
      OP_MULXUU: o_result = w_hu;
      OP_MULXSU: o_result = w_hu - (i_a[31] ? i_b : '0);
      default:   o_result = w_hu - (i_a[31] ? i_b : '0) - (i_b[31] ? i_a : '0);
    endcase
  end

endmodule

// File: rtl/parallel_cpu_2_mult_seq.sv
// Issue-side sequencer for the 16x16 three-partial-product multiply cell.
// Runs one low pass (and a second high pass for MULX ops) and returns the combined word.
module parallel_cpu_2_mult_seq
  import parallel_cpu_2_mult_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CELL_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              kill,
  output logic [DATA_W-1:0] cell_src1,
  output logic [DATA_W-1:0] cell_src2,
  output logic              cell_en,
  input  logic [DATA_W-1:0] cell_p1,
  input  logic [DATA_W-1:0] cell_p2,
  input  logic [DATA_W-1:0] cell_p3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data
);

  localparam logic [1:0] CNT_INIT = 2'(CELL_LAT - 1);

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [DATA_W-1:0] r_a, r_b;
  logic [DATA_W-1:0] r_p1, r_p2, r_p3;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_cnt;

  logic              w_accept, w_expire, w_is_x;
  logic              w_load_cnt, w_cap_lo, w_cap_rsp;
  logic [DATA_W-1:0] w_c_p1, w_c_p2, w_c_p3, w_result;

  assign req_ready = (r_state == S_IDLE) && !kill;
  assign rsp_valid = (r_state == S_RESP) && !kill;
  assign rsp_data  = r_data;
  assign w_accept  = req_valid && req_ready;
  assign w_expire  = (r_cnt == '0);
  assign w_is_x    = (r_op != OP_MUL);

  always_comb begin
    w_next     = r_state;
    cell_en    = 1'b0;
    cell_src1  = r_a;
    cell_src2  = r_b;
    w_load_cnt = 1'b0;
    w_cap_lo   = 1'b0;
    w_cap_rsp  = 1'b0;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_ISSUE_LO;
      S_ISSUE_LO: begin
        cell_en    = 1'b1;
        w_load_cnt = 1'b1;
        w_next     = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (w_expire) begin
          w_cap_lo = 1'b1;
          if (w_is_x) begin
            cell_src1  = {{HALF_W{1'b0}}, r_a[DATA_W-1:HALF_W]};
            cell_src2  = {{HALF_W{1'b0}}, r_b[DATA_W-1:HALF_W]};
            cell_en    = 1'b1;
            w_load_cnt = 1'b1;
            w_next     = S_WAIT_HI;
          end else begin
            w_cap_rsp = 1'b1;
            w_next    = S_RESP;
          end
        end
      end
      S_WAIT_HI: begin
        if (w_expire) begin
          w_cap_rsp = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP:     if (rsp_ready) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (kill) begin
      w_next    = S_IDLE;
      cell_en   = 1'b0;
      w_cap_rsp = 1'b0;
    end
  end

  // A MUL finishes in the low-capture cycle, so the combiner then reads the live cell outputs.
  assign w_c_p1 = (r_state == S_WAIT_LO) ? cell_p1 : r_p1;
  assign w_c_p2 = (r_state == S_WAIT_LO) ? cell_p2 : r_p2;
  assign w_c_p3 = (r_state == S_WAIT_LO) ? cell_p3 : r_p3;

  parallel_cpu_2_mult_combine u_combine (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_p1     (w_c_p1),
    .i_p2     (w_c_p2),
    .i_p3     (w_c_p3),
    .i_hh     (cell_p1),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_MUL;
      r_a     <= '0;
      r_b     <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_p3    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= op_e'(req_op);
        r_a  <= req_a;
        r_b  <= req_b;
      end
      if (w_load_cnt)       r_cnt <= CNT_INIT;
      else if (r_cnt != '0) r_cnt <= r_cnt - 2'd1;
      if (w_cap_lo) begin
        r_p1 <= cell_p1;
        r_p2 <= cell_p2;
        r_p3 <= cell_p3;
      end
      if (w_cap_rsp) r_data <= w_result;
    end
  end

endmodule

// File: tb/tb_parallel_cpu_2_mult_seq.sv
// Scoreboard bench: two sequencers (cell latency 1 and 2), each with a behavioural cell model.
module tb_parallel_cpu_2_mult_seq;

  typedef struct {
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, pr;
    xa = {(op[1]) ? {32{a[31]}} : 32'h0, a};
    xb = {(op == 2'b11) ? {32{b[31]}} : 32'h0, b};
    pr = xa * xb;
    return (op == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  function automatic logic [31:0] lohi(input logic [31:0] x, input logic [31:0] y, input int sel);
    logic [31:0] r;
    case (sel)
      0:       r = {16'h0, x[15:0]} * {16'h0, y[15:0]};
      1:       r = {16'h0, x[15:0]} * {16'h0, y[31:16]};
      default: r = {16'h0, x[31:16]} * {16'h0, y[15:0]};
    endcase
    return r;
  endfunction

  // ---------------- DUT 1 : CELL_LAT = 1
  logic        rst1, rv1, rr1, k1, en1, vv1, rdy1;
  logic [1:0]  op1;
  logic [31:0] a1, b1, s1a, s1b, c1p1, c1p2, c1p3, d1;

  parallel_cpu_2_mult_seq #(.DATA_W(32), .CELL_LAT(1)) dut1 (
    .clk(clk), .reset_n(rst1), .req_valid(rv1), .req_ready(rr1), .req_op(op1),
    .req_a(a1), .req_b(b1), .kill(k1), .cell_src1(s1a), .cell_src2(s1b), .cell_en(en1),
    .cell_p1(c1p1), .cell_p2(c1p2), .cell_p3(c1p3),
    .rsp_valid(vv1), .rsp_ready(rdy1), .rsp_data(d1)
  );

  always @(posedge clk) if (en1) begin
    c1p1 <= lohi(s1a, s1b, 0);
    c1p2 <= lohi(s1a, s1b, 1);
    c1p3 <= lohi(s1a, s1b, 2);
  end

  // ---------------- DUT 2 : CELL_LAT = 2
  logic        rst2, rv2, rr2, k2, en2, vv2, rdy2;
  logic [1:0]  op2;
  logic [31:0] a2, b2, s2a, s2b, c2p1, c2p2, c2p3, d2;
  logic [31:0] st1, st2, st3;

  parallel_cpu_2_mult_seq #(.DATA_W(32), .CELL_LAT(2)) dut2 (
    .clk(clk), .reset_n(rst2), .req_valid(rv2), .req_ready(rr2), .req_op(op2),
    .req_a(a2), .req_b(b2), .kill(k2), .cell_src1(s2a), .cell_src2(s2b), .cell_en(en2),
    .cell_p1(c2p1), .cell_p2(c2p2), .cell_p3(c2p3),
    .rsp_valid(vv2), .rsp_ready(rdy2), .rsp_data(d2)
  );

  always @(posedge clk) begin
    if (en2) begin
      st1 <= lohi(s2a, s2b, 0);
      st2 <= lohi(s2a, s2b, 1);
      st3 <= lohi(s2a, s2b, 2);
    end
    c2p1 <= st1;
    c2p2 <= st2;
    c2p3 <= st3;
  end

  // ---------------- scoreboards and monitors
  exp_t q1[$];
  exp_t q2[$];
  logic prev_v1 = 1'b0, prev_v2 = 1'b0;
  int   en_cnt1 = 0;
  logic done2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (en1) en_cnt1++;
    if (vv1 && !prev_v1) begin
      if (q1.size() == 0) chk("spurious_rsp1", {31'h0, vv1}, 32'h0);
      else                chk("latency1", cyc, q1[0].cyc);
    end
    if (vv1 && rdy1 && q1.size() != 0) begin
      e = q1.pop_front();
      chk("data1", d1, e.data);
    end
    prev_v1 = vv1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (vv2 && !prev_v2) begin
      if (q2.size() == 0) chk("spurious_rsp2", {31'h0, vv2}, 32'h0);
      else                chk("latency2", cyc, q2[0].cyc);
    end
    if (vv2 && rdy2 && q2.size() != 0) begin
      e = q2.pop_front();
      chk("data2", d2, e.data);
    end
    prev_v2 = vv2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic [31:0] lat, input logic push);
    int n = 0;
    while (!rr1 && n < 60) begin step(); n++; end
    chk("ready1_wait", {31'h0, rr1}, 32'h1);
    rv1 = 1'b1; op1 = op; a1 = a; b1 = b;
    step();
    rv1 = 1'b0;
    if (push) q1.push_back('{exp, cyc + lat - 32'd1});
  endtask

  task automatic issue2(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!rr2 && n < 60) begin step(); n++; end
    chk("ready2_wait", {31'h0, rr2}, 32'h1);
    rv2 = 1'b1; op2 = op; a2 = a; b2 = b;
    step();
    rv2 = 1'b0;
    q2.push_back('{model(op, a, b), cyc + ((op == 2'b00) ? 32'd4 : 32'd6) - 32'd1});
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 100) begin step(); n++; end
    chk("drain1", q1.size(), 32'h0);
  endtask

  // ---------------- DUT 2 stimulus: directed signed/unsigned corners plus random ops
  logic [1:0]  v_op [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [31:0] v_a  [8] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000,
                            32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] v_b  [8] = '{32'h9ABC_DEF0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'h7FFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_0000};

  initial begin
    rst2 = 1'b0; rv2 = 1'b0; k2 = 1'b0; rdy2 = 1'b1; op2 = '0; a2 = '0; b2 = '0;
    step(); step();
    rst2 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) issue2(v_op[i], v_a[i], v_b[i]);
    for (int i = 0; i < 8; i++) issue2(2'($urandom_range(0, 3)), $urandom, $urandom);
    for (int n = 0; n < 100 && q2.size() != 0; n++) step();
    chk("drain2", q2.size(), 32'h0);
    done2 = 1'b1;
  end

  // ---------------- DUT 1 stimulus: directed vectors and control corners
  initial begin
    int e0;
    rst1 = 1'b0; rv1 = 1'b0; k1 = 1'b0; rdy1 = 1'b1; op1 = '0; a1 = '0; b1 = '0;
    step(); step();
    chk("rst_req_ready", {31'h0, rr1}, 32'h1);
    chk("rst_rsp_valid", {31'h0, vv1}, 32'h0);
    chk("rst_rsp_data",  d1, 32'h0);
    chk("rst_cell_en",   {31'h0, en1}, 32'h0);
    chk("rst_src1",      s1a, 32'h0);
    chk("rst_src2",      s1b, 32'h0);
    rst1 = 1'b1;
    step();

    issue1(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 32'd3, 1'b1);
    drain1();
    e0 = en_cnt1;
    issue1(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd4, 1'b1);
    drain1();
    chk("en_pulses_mulx", en_cnt1 - e0, 32'd2);
    issue1(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'd4, 1'b1);
    issue1(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 1'b1);
    drain1();

    // Backpressure: hold result for five cycles, then release with a request waiting.
    rdy1 = 1'b0;
    issue1(2'b00, 32'd7, 32'd9, 32'h0000_003F, 32'd3, 1'b1);
    for (int n = 0; n < 20 && !vv1; n++) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data",  d1, 32'h0000_003F);
      chk("bp_valid", {31'h0, vv1}, 32'h1);
      chk("bp_ready", {31'h0, rr1}, 32'h0);
      step();
    end
    rdy1 = 1'b1; rv1 = 1'b1; op1 = 2'b00; a1 = 32'd2; b1 = 32'd3;
    step();
    chk("ready_after_rsp", {31'h0, rr1}, 32'h1);
    step();
    rv1 = 1'b0;
    q1.push_back('{32'h0000_0006, cyc + 32'd2});
    drain1();

    // Kill in WAIT_LO: the high pass must not issue and nothing is returned.
    issue1(2'b01, 32'h1234_5678, 32'h8765_4321, 32'h0, 32'd4, 1'b0);
    step();
    k1 = 1'b1;
    #1;
    chk("kill_cell_en", {31'h0, en1}, 32'h0);
    chk("kill_req_ready", {31'h0, rr1}, 32'h0);
    step();
    k1 = 1'b0;
    #1;
    chk("kill_idle", {31'h0, rr1}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      chk("kill_no_rsp", {31'h0, vv1}, 32'h0);
      step();
    end

    // Asynchronous reset in WAIT_HI.
    issue1(2'b11, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0, 32'd4, 1'b0);
    step(); step();
    rst1 = 1'b0;
    #1;
    chk("arst_req_ready", {31'h0, rr1}, 32'h1);
    chk("arst_cell_en",   {31'h0, en1}, 32'h0);
    chk("arst_rsp_valid", {31'h0, vv1}, 32'h0);
    #1;
    rst1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("arst_no_rsp", {31'h0, vv1}, 32'h0);
    end

    issue1(2'b00, 32'd3, 32'd5, 32'h0000_000F, 32'd3, 1'b1);
    drain1();

    for (int n = 0; n < 2000 && !done2; n++) step();
    chk("dut2_done", {31'h0, done2}, 32'h1);
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
